// File: rtl/stopwatch_ctrl_if.sv
// Command pulses in, BCD time / status / multiplexed digit out for the stopwatch controller.
// master drives the button pulses; slave is the controller side.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       running;
  logic       wrap;
  logic [3:0] scan_digit;
  logic [2:0] scan_sel;

  modport master (
    output start_stop, clear,
    input  sec_ones, sec_tens, min_ones, running, wrap, scan_digit, scan_sel
  );

  modport slave (
    input  start_stop, clear,
    output sec_ones, sec_tens, min_ones, running, wrap, scan_digit, scan_sel
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// M:SS stopwatch: IDLE/RUN/PAUSE FSM, prescaled BCD counter, 3-digit display scan.
// Commands act on the edge they are sampled; no backpressure, inputs are single-cycle pulses.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic               clk,
  input  logic               reset,
  stopwatch_ctrl_if.slave    bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TICK_W-1:0]  presc;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         scan_sel;
  logic [3:0]         sec_ones;
  logic [3:0]         sec_tens;
  logic [3:0]         min_ones;
  logic               wrap;
  logic               tick;
  logic               at_max;
  logic [3:0]         scan_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // In PAUSE, clear outranks start_stop; in RUN, clear is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_stop) state_nxt = RUN;
      RUN:     if (bus.start_stop) state_nxt = PAUSE;
      PAUSE: begin
        if (bus.clear)           state_nxt = IDLE;
        else if (bus.start_stop) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tick   = (state == RUN) && (presc == TICK_MAX);
  assign at_max = (min_ones == 4'd9) && (sec_tens == 4'd5) && (sec_ones == 4'd9);

  // Prescaler holds through PAUSE so a resumed second keeps its partial progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (state_nxt == IDLE) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      wrap     <= 1'b0;
    end else begin
      wrap <= tick && at_max;
      if (state_nxt == IDLE) begin
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
      end else if (tick) begin
        if (sec_ones == 4'd9) begin
          sec_ones <= 4'd0;
          if (sec_tens == 4'd5) begin
            sec_tens <= 4'd0;
            min_ones <= (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
          end else begin
            sec_tens <= sec_tens + 4'd1;
          end
        end else begin
          sec_ones <= sec_ones + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_sel <= 3'b001;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      scan_sel <= {scan_sel[1:0], scan_sel[2]};
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    scan_digit = 4'd0;
    case (scan_sel)
      3'b001:  scan_digit = sec_ones;
      3'b010:  scan_digit = sec_tens;
      3'b100:  scan_digit = min_ones;
      default: scan_digit = 4'd0;
    endcase
  end

  assign bus.sec_ones   = sec_ones;
  assign bus.sec_tens   = sec_tens;
  assign bus.min_ones   = min_ones;
  assign bus.running    = (state == RUN);
  assign bus.wrap       = wrap;
  assign bus.scan_sel   = scan_sel;
  assign bus.scan_digit = scan_digit;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, SCAN_DIV=2.
// Vector table for reset/run/pause/resume, then hand sequences for clear, carry, wrap, reset.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   kcnt = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ss;
    logic       clr;
    logic       run;
    logic       wrap;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, s, c, run, w, input logic [3:0] m, t, o);
    vec_t v;
    v.rst = r; v.ss = s; v.clr = c; v.run = run; v.wrap = w;
    v.m = m; v.t = t; v.o = o;
    vecs.push_back(v);
  endfunction

  // Inputs change 1 time unit after the edge; kcnt counts edges since the last reset edge.
  task automatic step(input logic r, s, c);
    reset = r;
    sw_if.start_stop = s;
    sw_if.clear = c;
    @(posedge clk);
    #1;
    if (r) kcnt = 0;
    else kcnt++;
  endtask

  task automatic run_idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  // Scan expectation: dwell of 2 edges per digit, starting at sec_ones after reset.
  task automatic check(input string name, input logic run, w, input logic [3:0] m, t, o);
    logic [2:0]  esel;
    logic [3:0]  edig;
    logic [20:0] act;
    logic [20:0] exp;
    int          idx;
    idx  = (kcnt / 2) % 3;
    esel = 3'b001 << idx;
    edig = (idx == 0) ? o : (idx == 1) ? t : m;
    act  = {sw_if.running, sw_if.wrap, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones,
            sw_if.scan_sel, sw_if.scan_digit};
    exp  = {run, w, m, t, o, esel, edig};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got run=%b wrap=%b %h:%h%h sel=%b dig=%h, expected run=%b wrap=%b %h:%h%h sel=%b dig=%h",
               name, act[20], act[19], act[18:15], act[14:11], act[10:7], act[6:4], act[3:0],
               run, w, m, t, o, esel, edig);
    end
  endtask

  initial begin
    sw_if.start_stop = 1'b0;
    sw_if.clear = 1'b0;

    // rst ss clr | run wrap m t o
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);   // first tick 4 cycles after start
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0, 2);   // pause 2 cycles after the tick
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 1, 0, 0, 0, 2);   // resume
    add(0, 0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 0, 3);   // 2 cycles after resume
    add(0, 0, 1, 1, 0, 0, 0, 3);   // clear ignored in RUN
    add(0, 0, 0, 1, 0, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 0, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ss, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].run, vecs[i].wrap, vecs[i].m, vecs[i].t, vecs[i].o);
    end

    // 0:04 -> 0:37, pause, clear
    run_idle(33 * 4);
    check("reach_0_37", 1, 0, 0, 3, 7);
    step(0, 1, 0);
    check("pause_0_37", 0, 0, 0, 3, 7);
    step(0, 0, 1);
    check("clear_pause", 0, 0, 0, 0, 0);
    // prescaler must restart from 0: tick exactly 4 cycles after start
    step(0, 1, 0);
    run_idle(3);
    check("presc_zero_pre", 1, 0, 0, 0, 0);
    step(0, 0, 0);
    check("presc_zero_tick", 1, 0, 0, 0, 1);

    // simultaneous pulses in PAUSE, IDLE, RUN
    step(0, 1, 0);
    step(0, 1, 1);
    check("both_in_pause", 0, 0, 0, 0, 0);
    step(0, 1, 1);
    check("both_in_idle", 1, 0, 0, 0, 0);
    step(0, 1, 1);
    check("both_in_run", 0, 0, 0, 0, 0);
    step(0, 0, 1);

    // sec_tens carry
    step(0, 1, 0);
    run_idle(59 * 4);
    check("reach_0_59", 1, 0, 0, 5, 9);
    run_idle(3);
    check("hold_0_59", 1, 0, 0, 5, 9);
    step(0, 0, 0);
    check("carry_1_00", 1, 0, 1, 0, 0);

    // 9:59 -> 0:00 wrap
    run_idle(539 * 4);
    check("reach_9_59", 1, 0, 9, 5, 9);
    run_idle(3);
    check("pre_wrap", 1, 0, 9, 5, 9);
    step(0, 0, 0);
    check("wrap_edge", 1, 1, 0, 0, 0);
    step(0, 0, 0);
    check("wrap_drop", 1, 0, 0, 0, 0);
    run_idle(3);
    check("after_wrap", 1, 0, 0, 0, 1);

    // reset at 3:42 with a start_stop in the same cycle
    run_idle(221 * 4);
    check("reach_3_42", 1, 0, 3, 4, 2);
    step(1, 1, 0);
    check("reset_mid_run", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    check("idle_after_reset", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Minute/second stopwatch controller between the push-button chattering eliminators and the seven-segment decoder stage. It consumes the eliminators' single-cycle `out_signal` pulses as start/stop and clear commands and runs a three-state control FSM. It advances a BCD time value M:SS on a prescaled tick. It also time-multiplexes the three digits onto one BCD output bus with a one-hot digit select, for a shared seven-segment decoder.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per counted second; legal range is 2 or more.
- `SCAN_DIV`, default 50_000: clk cycles per display digit slot; legal range is 2 or more.
- `clk`  in  1  the only clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start_stop`  in  1  single-cycle pulse from a chattering eliminator.
- `clear`  in  1  single-cycle pulse from a chattering eliminator.
- `sec_ones`  out  4  BCD 0–9, registered.
- `sec_tens`  out  4  BCD 0–5, registered.
- `min_ones`  out  4  BCD 0–9, registered.
- `running`  out  1  high when and only when state is RUN.
- `wrap`  out  1  one-cycle pulse when 9:59 rolls over to 0:00.
- `scan_digit`  out  4  BCD value of the currently selected digit.
- `scan_sel`  out  3  one-hot digit enable: 001 = sec_ones, 010 = sec_tens, 100 = min_ones.

## Operation
- **Reset** (sampled on a clk edge with `reset`=1):
  - state IDLE, all digits 0, prescaler 0, scan counter 0.
  - `scan_sel`=001, `running`=0, `wrap`=0.
  - Reset wins over any input in the same cycle, including mid-count.
- **FSM states:** IDLE (time 0:00, stopped), RUN, PAUSE.
- **Transitions** are evaluated each edge:
  - IDLE: `start_stop` → RUN; `clear` → stays IDLE.
  - RUN: `start_stop` → PAUSE; `clear` is ignored.
  - PAUSE: `start_stop` → RUN; `clear` → IDLE.
  - `start_stop` and `clear` in the same cycle:
    - In IDLE, go to RUN.
    - In PAUSE, `clear` has priority and the next state is IDLE.
    - In RUN, go to PAUSE (`clear` is still ignored).
- **Prescaler** (counts 0..`TICK_DIV`-1):
  - Increments only while the current state is RUN.
  - Holds its value in PAUSE, so a resumed second keeps its partial progress.
  - Forced to 0 whenever the next state is IDLE.
- **Tick:** prescaler = `TICK_DIV`-1 while in RUN. The prescaler then returns to 0 and the time advances by one second on that same edge.
  - A tick in the same cycle as a `start_stop` pulse is still counted.
- **Time increment rules:**
  - `sec_ones` 9 → 0 with carry into `sec_tens`.
  - `sec_tens` 5 → 0 with carry into `min_ones`.
  - 9:59 → 0:00, with `wrap`=1 for exactly the following cycle. Counting continues.
  - No digit ever holds a non-BCD value (`sec_tens` never exceeds 5).
- **Clear** into IDLE zeroes all digits on the same edge as the state change.
- **Scan:**
  - The scan counter runs 0..`SCAN_DIV`-1 in every state.
  - At terminal count it returns to 0 and `scan_sel` rotates 001 → 010 → 100 → 001.
  - `scan_digit` is a combinational mux of the registered `scan_sel` and registered digits. It always equals the digit selected by `scan_sel` in the same cycle.

## Timing
- Pulse → state: a `start_stop` or `clear` sampled at edge N takes effect at edge N. `running` reflects the new state after edge N (1-cycle latency from pulse assertion).
- Counting: the first tick after entering RUN from IDLE comes `TICK_DIV` cycles after the entering edge.
- Digits change on the tick edge. `wrap` is high for the cycle after the 9:59 → 0:00 edge.
- `scan_sel` dwell is exactly `SCAN_DIV` cycles per digit; the full rotation is 3×`SCAN_DIV`.
- Inputs are assumed to be at most 1 cycle wide. A held-high input is treated as a pulse on every cycle (toggles each cycle); no edge detection is done here.

## Test plan
Use `TICK_DIV`=4 and `SCAN_DIV`=2 for all scenarios.
- **Reset, then run:** reset, then `start_stop` pulse.
  - `running`=1 next cycle.
  - `sec_ones` 0 → 1 after 4 cycles, → 2 after 8 cycles.
  - `scan_sel` rotates 001, 010, 100 every 2 cycles with matching `scan_digit`.
- **Pause/resume:** pause 2 cycles after a tick, idle 10 cycles, resume.
  - Digits frozen during the pause.
  - Next increment 2 cycles after the resume edge.
- **Clear:**
  - `clear` during RUN: no effect.
  - `clear` in PAUSE at 0:37: digits 0:00, state IDLE, prescaler 0.
  - Simultaneous `start_stop`+`clear` in PAUSE ends in IDLE, `running`=0.
- **Carry/wrap:**
  - Run through 0:59 → 1:00 (sec_tens carry).
  - 9:59 → 0:00 with `wrap` high exactly 1 cycle, then counting continues to 0:01.
- **Reset mid-run:** assert `reset` at 3:42 with a `start_stop` pulse in the same cycle.
  - All outputs return to reset values, IDLE.
  - `scan_sel`=001, `scan_digit`=0.
